// File: rtl/arb_pkg.sv
// arb_pkg: shared sizes, FSM state encoding and mode encoding for the 8-way arbiter.
package arb_pkg;
    localparam int N_REQ = 8;
    localparam int ID_W = 3;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR = 1'b1;
    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
endpackage

// File: rtl/pri_enc_8to3.sv
// pri_enc_8to3: combinational priority encoder, highest set index wins.
module pri_enc_8to3
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    output logic [ID_W-1:0]  idx,
    output logic             valid
);
    always_comb begin
        idx = '0;
        for (int i = 0; i < N_REQ; i++) if (vec[i]) idx = ID_W'(i);
    end
    assign valid = |vec;
endmodule

// File: rtl/priority_arbiter_8.sv
// priority_arbiter_8: 8-way fixed/round-robin arbiter with hold limit and one-cycle gap between grants.
module priority_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD   = 16,
    parameter bit RR_DEFAULT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    input  logic             mode_wr,
    input  logic             mode_in,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);
    state_t           state, state_nx;
    logic             mode;
    logic [ID_W-1:0]  last, rot_amt, enc_idx, win;
    logic [7:0]       cnt;
    logic [N_REQ-1:0] rot;
    logic             enc_valid, owner_req, hit_max, release_now, grant_now;

    // Fixed priority is round-robin with a rotation of zero, so one encoder serves both modes.
    assign rot_amt = (mode == MODE_RR) ? last : '0;
    assign rot = N_REQ'({req, req} >> rot_amt);
    pri_enc_8to3 u_enc (.vec(rot), .idx(enc_idx), .valid(enc_valid));
    assign win = enc_idx + rot_amt;

    assign owner_req = req[gnt_id];
    assign hit_max = cnt == 8'(MAX_HOLD - 1);
    assign release_now = done || !owner_req || hit_max;
    assign grant_now = state == IDLE && enc_valid;

    always_comb begin
        state_nx = (state == IDLE) ? (enc_valid ? BUSY : IDLE) :
                   (state == BUSY) ? (release_now ? GAP : BUSY) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt <= '0;
            gnt_id <= '0;
            gnt_valid <= 1'b0;
            timeout <= 1'b0;
            cnt <= '0;
            last <= '0;
            mode <= RR_DEFAULT;
        end else begin
            state <= state_nx;
            mode <= mode_wr ? mode_in : mode;
            timeout <= state == BUSY && !done && owner_req && hit_max;
            if (grant_now) begin
                gnt <= N_REQ'(1) << win;
                gnt_id <= win;
                gnt_valid <= 1'b1;
                cnt <= '0;
                last <= win;
            end else if (state == BUSY) begin
                if (release_now) begin
                    gnt <= '0;
                    gnt_id <= '0;
                    gnt_valid <= 1'b0;
                end
                cnt <= (cnt == 8'hff) ? cnt : cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_priority_arbiter_8.sv
// tb_priority_arbiter_8: directed checks of arbitration, hold limit, gap and reset behaviour.
module tb_priority_arbiter_8;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done, mode_wr, mode_in;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid, timeout;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    priority_arbiter_8 #(.MAX_HOLD(4), .RR_DEFAULT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done), .mode_wr(mode_wr),
        .mode_in(mode_in), .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid),
        .timeout(timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"}, gnt, 8'h00);
        chk({tag, "_valid"}, gnt_valid, 1'b0);
    endtask

    task automatic chk_grant(input logic [2:0] id, input string tag);
        chk({tag, "_id"}, gnt_id, id);
        chk({tag, "_gnt"}, gnt, 8'h01 << id);
        chk({tag, "_valid"}, gnt_valid, 1'b1);
    endtask

    // Release the current owner with done, expect GAP and IDLE cycles, then the next grant.
    task automatic rel_next(input logic [2:0] id, input string tag);
        done = 1'b1;
        cyc();
        done = 1'b0;
        chk_idle({tag, "_gap"});
        chk({tag, "_to"}, timeout, 1'b0);
        cyc();
        chk_idle({tag, "_idle"});
        cyc();
        chk_grant(id, tag);
    endtask

    initial begin
        rst_n = 1'b0;
        req = 8'h00;
        done = 1'b0;
        mode_wr = 1'b0;
        mode_in = 1'b0;
        cyc();
        chk_idle("rst");
        chk("rst_id", gnt_id, 3'd0);
        chk("rst_to", timeout, 1'b0);
        rst_n = 1'b1;
        cyc();
        chk_idle("noreq");
        req = 8'b0010_0101;
        cyc();
        chk_grant(3'd5, "fix25");
        rel_next(3'd5, "regrant5");
        req = 8'hFF;
        cyc();
        chk_grant(3'd5, "nopreempt");
        rel_next(3'd7, "fixff_a");
        rel_next(3'd7, "fixff_b");
        rel_next(3'd7, "fixff_c");
        mode_wr = 1'b1;
        mode_in = 1'b1;
        rel_next(3'd6, "rr6");
        mode_wr = 1'b0;
        for (int k = 5; k >= 0; k--) rel_next(3'(k), "rr_seq");
        rel_next(3'd7, "rr_wrap");
        req = 8'h81;
        rel_next(3'd0, "rr81_0");
        rel_next(3'd7, "rr81_7");
        mode_wr = 1'b1;
        mode_in = 1'b0;
        rel_next(3'd7, "back_fixed");
        mode_wr = 1'b0;
        req = 8'h08;
        rel_next(3'd3, "hold_start");
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk_grant(3'd3, "holding");
            chk("hold_to", timeout, 1'b0);
        end
        cyc();
        chk_idle("to_gap");
        chk("to_pulse", timeout, 1'b1);
        cyc();
        chk_idle("to_idle");
        chk("to_once", timeout, 1'b0);
        cyc();
        chk_grant(3'd3, "to_regrant");
        cyc();
        cyc();
        cyc();
        chk_grant(3'd3, "both_pre");
        done = 1'b1;
        cyc();
        done = 1'b0;
        chk_idle("both_rel");
        chk("both_to", timeout, 1'b0);
        cyc();
        cyc();
        chk_grant(3'd3, "both_regrant");
        req = 8'h04;
        cyc();
        chk_idle("drop3");
        chk("drop3_to", timeout, 1'b0);
        cyc();
        cyc();
        chk_grant(3'd2, "own2");
        req = 8'h44;
        cyc();
        chk_grant(3'd2, "own2_hold");
        req = 8'h40;
        cyc();
        chk_idle("drop2");
        cyc();
        chk_idle("drop2_idle");
        cyc();
        chk_grant(3'd6, "own6");
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        chk("async_rst_id", gnt_id, 3'd0);
        chk("async_rst_last", dut.last, 3'd0);
        #1;
        rst_n = 1'b1;
        req = 8'h01;
        cyc();
        chk_grant(3'd0, "post_rst");
        chk("post_rst_last", dut.last, 3'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/priority_arbiter_8.md
PRIORITY_ARBITER_8 -- requirements
Module: priority_arbiter_8

Interface
REQ-001 Parameter MAX_HOLD, default 16, maximum number of cycles a grant is held before forced release (legal range 2..255).
REQ-002 Parameter RR_DEFAULT, default 0, reset value of the mode register (0 = fixed priority, 1 = round-robin).
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req  input  8  request lines; req[7] has the highest fixed priority and req[0] the lowest.
REQ-006 done  input  1  one-cycle release pulse from the current owner.
REQ-007 mode_wr  input  1  mode write strobe.
REQ-008 mode_in  input  1  new mode value; applied only when mode_wr = 1.
REQ-009 gnt  output  8  one-hot grant, registered.
REQ-010 gnt_id  output  3  binary index of the owner, registered.
REQ-011 gnt_valid  output  1  high while any grant is active.
REQ-012 timeout  output  1  one-cycle pulse when MAX_HOLD forces a release.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY and GAP.
REQ-014 IDLE, with req != 0: select a winner, load gnt/gnt_id, set gnt_valid = 1, clear the hold counter, go to BUSY; the grant is visible 1 cycle after req is sampled.
REQ-015 IDLE, with req == 0: outputs SHALL stay 0 and the FSM SHALL remain in IDLE.
REQ-016 Fixed mode: the winner SHALL be the highest-index asserted req bit.
REQ-017 Round-robin mode: the search SHALL run descending from last-1, wrapping 0 to 7, where last is the most recently granted index.
REQ-018 In both modes, last SHALL update to the winner on every grant.
REQ-019 BUSY: the hold counter SHALL increment by 1 each cycle.
REQ-020 BUSY release causes, in priority order:
- (a) done = 1;
- (b) req[gnt_id] = 0;
- (c) hold counter == MAX_HOLD-1, which SHALL also pulse timeout for one cycle.
REQ-021 On any release, gnt, gnt_id and gnt_valid SHALL clear on the next edge and the FSM SHALL go to GAP.
REQ-022 GAP SHALL last exactly 1 cycle with all grant outputs at 0, then go to IDLE; there are no back-to-back grants without a GAP cycle.
REQ-023 While BUSY, changes to other req bits SHALL NOT affect the grant (no preemption).
REQ-024 done asserted in IDLE or GAP SHALL be ignored.
REQ-025 Simultaneous done and timeout condition: a single release occurs and timeout SHALL NOT pulse.
REQ-026 mode_wr takes effect at the next edge; a grant in progress SHALL be unaffected, and the next IDLE arbitration uses the new mode.
REQ-027 gnt SHALL always be one-hot or zero, and gnt_valid SHALL equal |gnt.
REQ-028 The hold counter width SHALL be 8 bits; it SHALL saturate and never wrap.

Reset
REQ-029 While rst_n = 0, asynchronously: state = IDLE, gnt = 0, gnt_id = 0, gnt_valid = 0, timeout = 0, hold counter = 0, last = 0, mode = RR_DEFAULT.
REQ-030 With last = 0, the round-robin search order after reset SHALL be 7..0, identical to fixed priority.
REQ-031 Reset asserted mid-grant SHALL drop all grant outputs immediately, without waiting for a clock edge.
REQ-032 After rst_n deasserts, the first arbitration SHALL occur on the first edge at which req != 0.

Structure
REQ-033 Shared package arb_pkg SHALL hold: N_REQ = 8, ID_W = 3, the state enum (IDLE, BUSY, GAP), and the encoding constants MODE_FIXED and MODE_RR.
REQ-034 Sub-module pri_enc_8to3 SHALL be instantiated: combinational, 8-bit input to 3-bit index plus valid, highest index wins.
REQ-035 Round-robin SHALL be implemented as a rotate of req by last, then pri_enc_8to3, then a rotate-back of the index; no second encoder.

Verification
REQ-036 Reset, fixed mode: req = 8'b0010_0101 -> one cycle later gnt = 8'b0010_0000, gnt_id = 5, gnt_valid = 1.
REQ-037 Fixed mode, req held at 8'hFF, done pulsed each grant -> gnt_id sequence 7,7,7 with a 1-cycle GAP between each grant.
REQ-038 Round-robin mode, req held at 8'hFF, done pulsed -> gnt_id sequence 7,6,5,...,0,7; the req = 8'h81 pattern alternates 7,0,7.
REQ-039 MAX_HOLD = 4, req = 8'h08 held, no done -> gnt_valid high for 4 cycles, timeout pulses once, 1 GAP cycle, then regrant to id 3.
REQ-040 BUSY on id 2, req[2] dropped while req[6] rises -> release, GAP, then grant to id 6; no preemption occurs before the release.
REQ-041 rst_n pulled low mid-grant -> gnt = 0 within the same cycle; after release, req = 8'h01 -> gnt_id = 0 and last = 0.
